// File: rtl/tank_input_mapper_pkg.sv
// Shared constants and types for the vector-tank control-input front end.
package tank_input_pkg;

    localparam logic [7:0] MOD_BZONE    = 8'd0;
    localparam logic [7:0] MOD_BRADLEY  = 8'd1;
    localparam logic [7:0] MOD_REDBARON = 8'd2;

    // Bit positions inside each player's 16-bit digital joystick word.
    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;

    // Tread nibble is {Lfw, Lbk, Rfw, Rbk}.
    localparam int TR_RBK = 0;
    localparam int TR_RFW = 1;
    localparam int TR_LBK = 2;
    localparam int TR_LFW = 3;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_GAP   = 2'd2
    } coin_state_e;

    // Magnitude of a signed byte; -128 yields 128.
    function automatic logic [8:0] abs8(input logic [7:0] v);
        return v[7] ? (9'd0 - {v[7], v}) : {1'b0, v};
    endfunction

endpackage

// File: rtl/tank_input_mapper_if.sv
// HPS download bus feeding the mod/DIP capture registers.
interface tank_input_mapper_if;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
    modport slave  (input  ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/tank_input_mapper_tread.sv
// Combinational 8-way direction {U,D,L,R} to dual-tread {Lfw,Lbk,Rfw,Rbk} decode.
module dpad_tread_decode
    import tank_input_pkg::*;
(
    input  logic [3:0] i_dir,
    output logic [3:0] o_tread
);

    always_comb begin
        o_tread = '0;
        case (i_dir)
            4'b1000: begin o_tread[TR_LFW] = 1'b1; o_tread[TR_RFW] = 1'b1; end
            4'b1010: o_tread[TR_RFW] = 1'b1;
            4'b1001: o_tread[TR_LFW] = 1'b1;
            4'b0001: begin o_tread[TR_LFW] = 1'b1; o_tread[TR_RBK] = 1'b1; end
            4'b0101: o_tread[TR_LBK] = 1'b1;
            4'b0100: begin o_tread[TR_LBK] = 1'b1; o_tread[TR_RBK] = 1'b1; end
            4'b0110: o_tread[TR_RBK] = 1'b1;
            4'b0010: begin o_tread[TR_LBK] = 1'b1; o_tread[TR_RFW] = 1'b1; end
            default: o_tread = '0;
        endcase
    end

endmodule

// File: rtl/tank_input_mapper.sv
// Control-input front end for Battlezone / Bradley / Red Baron: download capture,
// joystick merge, tread decode, coin conditioning and a two-stage output pipeline.
module tank_input_mapper
    import tank_input_pkg::*;
#(
    parameter int NUM_PLAYERS       = 2,
    parameter int DSW_BYTES         = 2,
    parameter int COIN_PULSE_CYCLES = 16,
    parameter int COIN_GAP_CYCLES   = 16,
    parameter int DEADZONE          = 24
)(
    input  logic                      clk_sys,
    input  logic                      reset,
    tank_input_mapper_if.slave        dl,
    input  logic [NUM_PLAYERS*16-1:0] joy,
    input  logic [15:0]               joya,
    input  logic                      analog_treads,
    input  logic                      analog_sel,
    output logic [7:0]                mod,
    output logic [DSW_BYTES*8-1:0]    dsw,
    output logic [7:0]                jb,
    output logic [7:0]                arcade_buttons,
    output logic [7:0]                aux_buttons,
    output logic                      coin_pulse
);

    localparam int MAXC = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ? COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // Download capture lives outside reset so game settings survive a core reset.
    logic [7:0]                r_mod = 8'hFF;
    logic [DSW_BYTES-1:0][7:0] r_dsw = '0;

    always_ff @(posedge clk_sys) begin
        if (dl.ioctl_wr && dl.ioctl_index == 8'd1)
            r_mod <= dl.ioctl_dout;
        for (int i = 0; i < DSW_BYTES; i++)
            if (dl.ioctl_wr && dl.ioctl_index == 8'd254 && dl.ioctl_addr == 25'(i))
                r_dsw[i] <= dl.ioctl_dout;
    end

    assign mod = r_mod;
    assign dsw = r_dsw;

    logic [7:0]               w_joy_or;
    logic [NUM_PLAYERS*8-1:0] w_unused_joy_hi;

    always_comb begin
        w_joy_or        = '0;
        w_unused_joy_hi = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_joy_or                  = w_joy_or | joy[p*16 +: 8];
            w_unused_joy_hi[p*8 +: 8] = joy[p*16+8 +: 8];
        end
    end

    logic [7:0] w_x, w_y;
    logic       w_x_act, w_y_act;
    logic [3:0] w_adir, w_dir, w_tread;

    assign w_x     = joya[7:0];
    assign w_y     = joya[15:8];
    assign w_x_act = abs8(w_x) > 9'(DEADZONE);
    assign w_y_act = abs8(w_y) > 9'(DEADZONE);

    // Screen-space Y grows downward, so a negative Y reads as Up.
    always_comb begin
        w_adir        = '0;
        w_adir[JOY_U] = w_y_act &  w_y[7];
        w_adir[JOY_D] = w_y_act & ~w_y[7];
        w_adir[JOY_L] = w_x_act &  w_x[7];
        w_adir[JOY_R] = w_x_act & ~w_x[7];
    end

    assign w_dir = analog_treads ? w_adir : w_joy_or[3:0];

    dpad_tread_decode u_tread (
        .i_dir   (w_dir),
        .o_tread (w_tread)
    );

    // Stage 1
    logic [6:0] r_joy;
    logic [3:0] r_tread;
    logic [7:0] r_xb, r_yb;
    logic       r_sel;
    logic       r_coin_d, r_coin_edge;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_joy       <= '0;
            r_tread     <= '0;
            r_xb        <= '0;
            r_yb        <= '0;
            r_sel       <= 1'b0;
            r_coin_d    <= 1'b1;
            r_coin_edge <= 1'b0;
        end else begin
            r_joy       <= w_joy_or[6:0];
            r_tread     <= w_tread;
            r_xb        <= w_x + 8'd128;
            r_yb        <= w_y + 8'd128;
            r_sel       <= analog_sel;
            r_coin_d    <= w_joy_or[JOY_COIN];
            r_coin_edge <= w_joy_or[JOY_COIN] & ~r_coin_d;
        end
    end

    coin_state_e   r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= COIN_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Edges arriving outside IDLE are simply not looked at, hence dropped.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            COIN_IDLE: begin
                if (r_coin_edge) begin
                    w_state_nx = COIN_PULSE;
                    w_cnt_nx   = '0;
                end
            end
            COIN_PULSE: begin
                if (r_cnt == CW'(COIN_PULSE_CYCLES - 1)) begin
                    w_state_nx = COIN_GAP;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            COIN_GAP: begin
                if (r_cnt == CW'(COIN_GAP_CYCLES - 1)) begin
                    w_state_nx = COIN_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = COIN_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign coin_pulse = (r_state == COIN_PULSE);

    // Stage 2 mapping; the tank layout is also the fallback for unknown codes.
    logic [7:0] w_jb_nx, w_arc_nx, w_aux_nx;

    always_comb begin
        w_jb_nx  = {coin_pulse, r_joy[JOY_START1], r_joy[JOY_START2], r_joy[JOY_FIRE], r_tread};
        w_arc_nx = {2'b00, r_joy[JOY_START1], r_joy[JOY_START2] | r_joy[JOY_FIRE], r_tread};
        w_aux_nx = '0;
        case (r_mod)
            MOD_REDBARON: begin
                w_jb_nx  = {~coin_pulse, r_joy[JOY_START1], r_joy[JOY_START2], r_joy[JOY_FIRE],
                            r_joy[JOY_D], r_joy[JOY_U], r_joy[JOY_R], r_joy[JOY_L]};
                w_arc_nx = r_sel ? r_xb : r_yb;
                w_aux_nx = {r_joy[JOY_FIRE], r_joy[JOY_START1], 6'b0};
            end
            MOD_BZONE, MOD_BRADLEY: ;
            default: ;
        endcase
    end

    logic [7:0] r_jb, r_arc, r_aux;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_jb  <= '0;
            r_arc <= '0;
            r_aux <= '0;
        end else begin
            r_jb  <= w_jb_nx;
            r_arc <= w_arc_nx;
            r_aux <= w_aux_nx;
        end
    end

    assign jb             = r_jb;
    assign arcade_buttons = r_arc;
    assign aux_buttons    = r_aux;

endmodule

// File: tb/tb_tank_input_mapper.sv
// Directed self-checking bench for tank_input_mapper.
module tb_tank_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] joy;
    logic [15:0] joya;
    logic        analog_treads, analog_sel;
    logic [7:0]  mod, jb, arcade_buttons, aux_buttons;
    logic [15:0] dsw;
    logic        coin_pulse;
    int          total = 0;
    int          bad   = 0;

    always #5 clk_sys = ~clk_sys;

    tank_input_mapper_if dl_if();

    tank_input_mapper u_dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .dl             (dl_if.slave),
        .joy            (joy),
        .joya           (joya),
        .analog_treads  (analog_treads),
        .analog_sel     (analog_sel),
        .mod            (mod),
        .dsw            (dsw),
        .jb             (jb),
        .arcade_buttons (arcade_buttons),
        .aux_buttons    (aux_buttons),
        .coin_pulse     (coin_pulse)
    );

    // d-pad nibble {U,D,L,R} and expected treads {Lfw,Lbk,Rfw,Rbk}
    logic [3:0] tv_dir [10] = '{4'h8, 4'hA, 4'h9, 4'h1, 4'h5, 4'h4, 4'h6, 4'h2, 4'hC, 4'h3};
    logic [3:0] tv_tr  [10] = '{4'hA, 4'h2, 4'h8, 4'h9, 4'h4, 4'h5, 4'h1, 4'h6, 4'h0, 4'h0};

    // analog stick {Y,X} and expected treads, DEADZONE 24
    logic [15:0] av_joya [8] = '{16'h9C14, 16'h9CE2, 16'h0019, 16'h0018,
                                 16'h00E8, 16'h0080, 16'h8000, 16'h6400};
    logic [3:0]  av_tr   [8] = '{4'hA, 4'h2, 4'h9, 4'h0, 4'h0, 4'h6, 4'hA, 4'h5};

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic dl_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        dl_if.ioctl_wr    = 1'b1;
        dl_if.ioctl_index = idx;
        dl_if.ioctl_addr  = a;
        dl_if.ioctl_dout  = d;
        tick();
        dl_if.ioctl_wr    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        total++; if (mod !== 8'hFF) begin bad++; $display("FAIL rst_mod got %h want ff", mod); end
        total++; if (dsw !== 16'h0000) begin bad++; $display("FAIL rst_dsw got %h want 0000", dsw); end
        joy = 32'h0000_0018;
        repeat (3) tick();
        total++; if (jb !== 8'h00) begin bad++; $display("FAIL rst_jb got %h want 00", jb); end
        total++; if (arcade_buttons !== 8'h00) begin bad++; $display("FAIL rst_arc got %h want 00", arcade_buttons); end
        total++; if (aux_buttons !== 8'h00) begin bad++; $display("FAIL rst_aux got %h want 00", aux_buttons); end
        total++; if (coin_pulse !== 1'b0) begin bad++; $display("FAIL rst_coin got %b want 0", coin_pulse); end
        joy   = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_download();
        dl_write(8'd1, 25'd0, 8'h02);
        total++; if (mod !== 8'h02) begin bad++; $display("FAIL dl_mod got %h want 02", mod); end
        dl_write(8'd254, 25'd0, 8'hA5);
        dl_write(8'd254, 25'd1, 8'h5A);
        dl_write(8'd254, 25'd2, 8'hFF);
        dl_write(8'd253, 25'd0, 8'h11);
        total++; if (dsw !== 16'h5AA5) begin bad++; $display("FAIL dl_dsw got %h want 5aa5", dsw); end
        reset = 1'b1;
        tick();
        total++; if (mod !== 8'h02) begin bad++; $display("FAIL dl_mod_rst got %h want 02", mod); end
        dl_write(8'd1, 25'd0, 8'h00);
        reset = 1'b0;
        total++; if (mod !== 8'h00) begin bad++; $display("FAIL dl_mod_in_rst got %h want 00", mod); end
        total++; if (dsw !== 16'h5AA5) begin bad++; $display("FAIL dl_dsw_rst got %h want 5aa5", dsw); end
        tick();
    endtask

    task automatic test_battlezone();
        joy = 32'h0000_0009;
        tick(); tick();
        total++; if (jb !== 8'h08) begin bad++; $display("FAIL bz_ur_jb got %h want 08", jb); end
        joy = 32'h0010_0009;
        tick();
        total++; if (jb !== 8'h08) begin bad++; $display("FAIL bz_lat1_jb got %h want 08", jb); end
        tick();
        total++; if (jb !== 8'h18) begin bad++; $display("FAIL bz_fire_jb got %h want 18", jb); end
        total++; if (arcade_buttons !== 8'h18) begin bad++; $display("FAIL bz_fire_arc got %h want 18", arcade_buttons); end
        total++; if (aux_buttons !== 8'h00) begin bad++; $display("FAIL bz_aux got %h want 00", aux_buttons); end
        joy = 32'h0040_0000;
        tick(); tick();
        total++; if (jb !== 8'h20) begin bad++; $display("FAIL bz_s2_jb got %h want 20", jb); end
        total++; if (arcade_buttons !== 8'h10) begin bad++; $display("FAIL bz_s2_arc got %h want 10", arcade_buttons); end
        joy = 32'h0000_0020;
        tick(); tick();
        total++; if (jb !== 8'h40) begin bad++; $display("FAIL bz_s1_jb got %h want 40", jb); end
        total++; if (arcade_buttons !== 8'h20) begin bad++; $display("FAIL bz_s1_arc got %h want 20", arcade_buttons); end
        for (int i = 0; i < 10; i++) begin
            joy = {28'h0, tv_dir[i]};
            tick(); tick();
            total++;
            if (jb !== {4'h0, tv_tr[i]}) begin
                bad++; $display("FAIL tread_tbl dir=%h got %h want %h", tv_dir[i], jb, {4'h0, tv_tr[i]});
            end
        end
        joy = '0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [5] = '{8'h08, 8'h01, 8'h04, 8'h02, 8'h00};
        logic [7:0] e [4] = '{8'h0A, 8'h09, 8'h05, 8'h06};
        for (int i = 0; i < 5; i++) begin
            joy = {24'h0, v[i]};
            tick();
            if (i >= 1) begin
                total++;
                if (jb !== e[i-1]) begin bad++; $display("FAIL b2b_%0d got %h want %h", i, jb, e[i-1]); end
            end
        end
        tick();
    endtask

    task automatic test_coin();
        int highs, first_hi, first_jb7, rises;
        logic prev;
        highs = 0; first_hi = -1; first_jb7 = -1; rises = 0; prev = 1'b0;
        joy = 32'h0000_0080;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (coin_pulse === 1'b1) begin
                highs++;
                if (first_hi < 0) first_hi = n;
                if (!prev) rises++;
            end
            if (jb[7] === 1'b1 && first_jb7 < 0) first_jb7 = n;
            prev = coin_pulse;
        end
        total++; if (highs != 16) begin bad++; $display("FAIL coin_width got %0d want 16", highs); end
        total++; if (rises != 1) begin bad++; $display("FAIL coin_count got %0d want 1", rises); end
        total++; if (first_hi != 2) begin bad++; $display("FAIL coin_lat got %0d want 2", first_hi); end
        total++; if (first_jb7 != 3) begin bad++; $display("FAIL coin_jb7_lat got %0d want 3", first_jb7); end
        joy = '0;
        tick(); tick();
        highs = 0;
        joy = 32'h0000_0080;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (coin_pulse === 1'b1) highs++;
            if (n == 3)  joy = '0;
            if (n == 22) joy = 32'h0080_0000;
            if (n == 25) joy = '0;
        end
        total++; if (highs != 16) begin bad++; $display("FAIL coin_gap_drop got %0d want 16", highs); end
        joy = 32'h0000_0080;
        tick();
        total++; if (coin_pulse !== 1'b0) begin bad++; $display("FAIL coin_new_lat1 got %b want 0", coin_pulse); end
        tick();
        total++; if (coin_pulse !== 1'b1) begin bad++; $display("FAIL coin_new got %b want 1", coin_pulse); end
        joy = '0;
        repeat (40) tick();
    endtask

    task automatic test_coin_reset();
        int highs;
        highs = 0;
        joy   = 32'h0000_0080;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (coin_pulse === 1'b1) highs++;
        end
        total++; if (highs != 0) begin bad++; $display("FAIL coin_held_rst got %0d want 0", highs); end
        joy = '0;
        tick(); tick();
        joy = 32'h0000_0080;
        tick(); tick();
        total++; if (coin_pulse !== 1'b1) begin bad++; $display("FAIL coin_pre_rst got %b want 1", coin_pulse); end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total++; if (coin_pulse !== 1'b0) begin bad++; $display("FAIL coin_mid_rst got %b want 0", coin_pulse); end
        total++; if (jb !== 8'h00) begin bad++; $display("FAIL coin_mid_rst_jb got %h want 00", jb); end
        reset = 1'b0;
        joy   = '0;
        repeat (3) tick();
    endtask

    task automatic test_analog();
        analog_treads = 1'b1;
        joy = 32'h0000_0004;
        for (int i = 0; i < 8; i++) begin
            joya = av_joya[i];
            tick(); tick();
            total++;
            if (jb !== {4'h0, av_tr[i]}) begin
                bad++; $display("FAIL analog_jb joya=%h got %h want %h", av_joya[i], jb, {4'h0, av_tr[i]});
            end
            total++;
            if (arcade_buttons !== {4'h0, av_tr[i]}) begin
                bad++; $display("FAIL analog_arc joya=%h got %h want %h", av_joya[i], arcade_buttons, {4'h0, av_tr[i]});
            end
        end
        analog_treads = 1'b0;
        joy  = '0;
        joya = '0;
        tick(); tick();
    endtask

    task automatic test_redbaron();
        dl_write(8'd1, 25'd0, 8'h02);
        joya       = 16'h4081;
        analog_sel = 1'b1;
        tick(); tick();
        total++; if (arcade_buttons !== 8'h01) begin bad++; $display("FAIL rb_x got %h want 01", arcade_buttons); end
        total++; if (jb !== 8'h80) begin bad++; $display("FAIL rb_idle_jb got %h want 80", jb); end
        total++; if (aux_buttons !== 8'h00) begin bad++; $display("FAIL rb_idle_aux got %h want 00", aux_buttons); end
        analog_sel = 1'b0;
        tick();
        total++; if (arcade_buttons !== 8'h01) begin bad++; $display("FAIL rb_lat1 got %h want 01", arcade_buttons); end
        tick();
        total++; if (arcade_buttons !== 8'hC0) begin bad++; $display("FAIL rb_y got %h want c0", arcade_buttons); end
        analog_sel = 1'b1;
        tick(); tick();
        total++; if (arcade_buttons !== 8'h01) begin bad++; $display("FAIL rb_x2 got %h want 01", arcade_buttons); end
        joya = 16'h0080;
        tick(); tick();
        total++; if (arcade_buttons !== 8'h00) begin bad++; $display("FAIL rb_xmin got %h want 00", arcade_buttons); end
        joy = 32'h0000_0030;
        tick(); tick();
        total++; if (jb !== 8'hD0) begin bad++; $display("FAIL rb_btn_jb got %h want d0", jb); end
        total++; if (aux_buttons !== 8'hC0) begin bad++; $display("FAIL rb_aux got %h want c0", aux_buttons); end
        joy = 32'h0000_0009;
        tick(); tick();
        total++; if (jb !== 8'h86) begin bad++; $display("FAIL rb_ur_jb got %h want 86", jb); end
        joy = 32'h0040_0004;
        tick(); tick();
        total++; if (jb !== 8'hA8) begin bad++; $display("FAIL rb_p1_jb got %h want a8", jb); end
        joy  = '0;
        joya = '0;
        tick(); tick();
    endtask

    task automatic test_default_mod();
        dl_write(8'd1, 25'd0, 8'h07);
        joy = 32'h0000_0008;
        tick(); tick();
        total++; if (jb !== 8'h0A) begin bad++; $display("FAIL dflt_jb got %h want 0a", jb); end
        total++; if (aux_buttons !== 8'h00) begin bad++; $display("FAIL dflt_aux got %h want 00", aux_buttons); end
        joy = '0;
        tick(); tick();
    endtask

    initial begin
        joy               = '0;
        joya              = '0;
        analog_treads     = 1'b0;
        analog_sel        = 1'b0;
        dl_if.ioctl_wr    = 1'b0;
        dl_if.ioctl_index = '0;
        dl_if.ioctl_addr  = '0;
        dl_if.ioctl_dout  = '0;
        #1;
        test_reset();
        test_download();
        test_battlezone();
        test_back_to_back();
        test_coin();
        test_coin_reset();
        test_analog();
        test_redbaron();
        test_default_mod();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tank_input_mapper.md
# tank_input_mapper

Parametrised control-input front end for the vector-tank cores (Battlezone, Bradley, Red Baron). Captures game-mode and DIP bytes from the HPS download stream and ORs the digital joysticks of all players. Converts 8-way or analog sticks to dual-tread signals, conditions coin presses into fixed-width pulses, and registers per-game JB, button and auxiliary buses for the game top. Sits between `hps_io` and the game top inside `emu`.

## Interface
- `NUM_PLAYERS`, 2: joystick count; digital buses are ORed.
- `DSW_BYTES`, 2: DIP bytes captured from download index 254.
- `COIN_PULSE_CYCLES`, 16: coin pulse width in clocks; ≥1.
- `COIN_GAP_CYCLES`, 16: minimum low time after a pulse; ≥1.
- `DEADZONE`, 24: analog magnitude treated as centre; 0..127.
- `clk_sys  in  1`: sole clock.
- `reset  in  1`: synchronous, active-high.
- `ioctl_wr  in  1`: download write strobe.
- `ioctl_index  in  8`: download index.
- `ioctl_addr  in  25`: download address.
- `ioctl_dout  in  8`: download data.
- `joy  in  NUM_PLAYERS*16`: digital sticks, player 0 in bits [15:0]. Bit map: 0 R, 1 L, 2 D, 3 U, 4 fire, 5 start1, 6 start2, 7 coin.
- `joya  in  16`: player-0 analog stick, signed X in [7:0], signed Y in [15:8].
- `analog_treads  in  1`: 1 = tread decode from `joya` instead of the d-pad.
- `analog_sel  in  1`: game-side axis select for Red Baron, 1 = X.
- `mod  out  8`: captured game code.
- `dsw  out  DSW_BYTES*8`: DIP bytes, byte 0 in [7:0].
- `jb  out  8`: {coin, start1, start2, fire, Lfw, Lbk, Rfw, Rbk}.
- `arcade_buttons  out  8`: POKEY button byte or analog axis.
- `aux_buttons  out  8`: Red Baron {fire, start1, 6'b0}; 0 otherwise.
- `coin_pulse  out  1`: conditioned coin, active-high.

## Operation
- Mod codes: 0 Battlezone, 1 Bradley, 2 Red Baron. Any other value uses Battlezone mapping.
- Mod capture:
  - `ioctl_wr && ioctl_index==1` loads `mod`.
  - `ioctl_wr && ioctl_index==254 && ioctl_addr < DSW_BYTES` loads `dsw[addr]`. Other addresses are ignored.
  - Neither register is affected by `reset`; writes are accepted while `reset` is high.
  - Power-up values: `mod` = 8'hFF, `dsw` = 0.
- Tread decode from {U,D,L,R} to {Lfw,Lbk,Rfw,Rbk}:
  - U = 1010, U+L = 0010, U+R = 1000.
  - R = 1001, D+R = 0100, D = 0101.
  - D+L = 0001, L = 0110.
  - Any other combination, including U+D and L+R, gives 0000.
- Analog treads: an axis with |v| ≤ DEADZONE is 0. Otherwise negative X = L, positive X = R, negative Y = U, positive Y = D. The result feeds the same table. −128 counts as magnitude 128.
- Coin FSM, states IDLE / PULSE / GAP:
  - IDLE → PULSE on a rising edge of the ORed coin bit.
  - PULSE lasts COIN_PULSE_CYCLES clocks with `coin_pulse`=1, then → GAP.
  - GAP lasts COIN_GAP_CYCLES clocks, then → IDLE.
  - Edges seen in PULSE or GAP are dropped, not queued.
- Output mux, Battlezone/Bradley/default:
  - `jb` = {coin_pulse, start1, start2, fire, treads}.
  - `arcade_buttons` = {2'b00, start1, start2|fire, treads}.
- Output mux, Red Baron:
  - `jb` = {~coin_pulse, start1, start2, fire, D, U, R, L}.
  - `arcade_buttons` = axis + 8'd128, truncated to 8 bits, where axis is X if `analog_sel` else Y.
  - `aux_buttons` as in the port list.

## Timing
- Stage 1 registers the ORed joystick, tread decode, biased X/Y, `analog_sel` and the coin edge detect.
- Stage 2 registers `jb`, `arcade_buttons` and `aux_buttons`.
- Latency:
  - `joy`/`joya`/`analog_sel` to outputs: 2 clocks.
  - Coin rising edge to `coin_pulse`=1: 2 clocks. `jb[7]` follows 1 clock after `coin_pulse`.
  - `mod`/`dsw`: 1 clock after the write strobe. Output mapping switches on the next stage-2 update.
- While `reset` is high:
  - stage registers, `jb`, `arcade_buttons`, `aux_buttons` and `coin_pulse` are 0;
  - the FSM is in IDLE with counters at 0;
  - the coin edge-detect history is forced to 1, so a coin held across reset release does not fire.
- Reset mid-PULSE ends the pulse on the next clock. Counting restarts from IDLE.
- Simultaneous coin from several players counts as one edge.

## Structure
- `tank_input_pkg` holds:
  - mod code constants;
  - joystick bit index constants;
  - the coin FSM state enum;
  - the tread bit order.
- Sub-module `dpad_tread_decode` is purely combinational, 4-bit direction to 4-bit treads. It is instantiated once, fed by a mux of the d-pad or analog-derived directions.
- Counters are sized `$clog2(max(COIN_PULSE_CYCLES, COIN_GAP_CYCLES)+1)`.

## Test plan
- Download index 1 data 8'h02, then index 254 addr 0..2 data A5,5A,FF -> `mod`=02, `dsw`=16'h5AA5, addr 2 ignored. Values unchanged after `reset` pulse.
- Mod 0, joy0 = U+R (8'h09) -> `jb`=8'h08 after 2 clocks. Joy1 = fire (8'h10) added -> `jb`=8'h18, `arcade_buttons`=8'h18.
- Coin held 100 clocks -> exactly one `coin_pulse` of 16 clocks. A second edge 5 clocks into GAP -> no pulse. An edge after GAP ends -> new pulse.
- Mod 2, joya X=8'h81 (−127), Y=8'h40, analog_sel toggling 1/0 -> `arcade_buttons` alternates 8'h01 / 8'hC0 with 2-clock lag. Idle `jb[7]`=1.
- analog_treads=1, X=20, Y=−100, DEADZONE 24 -> treads 1010 (Up). X=−30 -> 0010 (U+L).
- Coin held through `reset` deassert -> no pulse. Reset asserted mid-PULSE -> `coin_pulse` 0 next clock.
